equiv_stim_gen: RTL and testbench

EQUIV_STIM_GEN -- requirements
Module: equiv_stim_gen

---
 rtl/equiv_stim_gen_if.sv | 31 +++
 rtl/equiv_stim_gen.sv | 137 +++++++++++++
 tb/tb_equiv_stim_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/equiv_stim_gen_if.sv
// Bundle between the equivalence stimulus generator and its environment:
// run control, the two responses under check, stimulus and run status.
interface equiv_stim_gen_if;
  // start is a one-cycle request with no ready: it is taken on the posedge
  // where the generator is in IDLE or DONE, and ignored in any other state.
  logic               start;
  logic        [90:0] y_1;
  logic        [90:0] y_2;
  logic         [3:0] wire0;
  logic        [15:0] wire1;
  logic        [19:0] wire2;
  logic signed [20:0] wire3;
  logic         [6:0] wire4;
  logic               busy;
  logic               done;
  logic               fail;
  logic        [31:0] fail_idx;
  logic        [31:0] vec_cnt;

  modport master (
    output start, y_1, y_2,
    input  wire0, wire1, wire2, wire3, wire4,
    input  busy, done, fail, fail_idx, vec_cnt
  );

  modport slave (
    input  start, y_1, y_2,
    output wire0, wire1, wire2, wire3, wire4,
    output busy, done, fail, fail_idx, vec_cnt
  );
endinterface

// File: rtl/equiv_stim_gen.sv
// LFSR-driven stimulus generator that compares two design responses with a
// fixed latency and records the index of the first mismatching vector.
module equiv_stim_gen #(
  parameter logic [63:0] SEED    = 64'h0000_0000_0000_0001,
  parameter int unsigned NUM_VEC = 1024,
  parameter int unsigned LAT     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  equiv_stim_gen_if.slave    bus,
  output logic [1:0]         dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned PD       = (LAT == 0) ? 1 : LAT;
  localparam logic [31:0] LAST_IDX = 32'(NUM_VEC - 1);
  localparam logic [31:0] NUM_VEC_W = 32'(NUM_VEC);

  logic [1:0]  state_q, state_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic [67:0] vec_q, vec_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fail_q, fail_d;
  logic [31:0] fidx_q, fidx_d;
  logic [PD-1:0] vld_q, vld_d;
  logic [31:0] idx_q [PD];
  logic [31:0] idx_d [PD];
  logic        run_vld;
  logic        cmp_vld;
  logic [31:0] cmp_idx;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // Packed as {wire0, wire1, wire2, wire3, wire4}.
  function automatic logic [67:0] stim_of(input logic [63:0] s);
    return {s[3:0], s[19:4], s[39:20], s[60:40], s[63:61], s[3:0]};
  endfunction

  // lfsr_q runs one step ahead of the vector on the wires, so the first RUN
  // cycle already presents the SEED vector from the register.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    fidx_d  = fidx_q;
    run_vld = (state_q == S_RUN);

    for (int i = int'(PD) - 1; i >= 1; i--) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    vld_d[0] = run_vld;
    idx_d[0] = cnt_q;

    if (LAT == 0) begin
      cmp_vld = run_vld;
      cmp_idx = cnt_q;
    end else begin
      cmp_vld = vld_q[PD-1];
      cmp_idx = idx_q[PD-1];
    end

    if (cmp_vld && (bus.y_1 != bus.y_2) && !fail_q) begin
      fail_d = 1'b1;
      fidx_d = cmp_idx;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          lfsr_d  = lfsr_step(SEED);
          vec_d   = stim_of(SEED);
          cnt_d   = '0;
          fail_d  = 1'b0;
          fidx_d  = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != NUM_VEC_W) cnt_d = cnt_q + 32'd1;
        if (cnt_q == LAST_IDX) begin
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          vec_d  = stim_of(lfsr_q);
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      S_DRAIN: begin
        if (vld_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      vec_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      fidx_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < int'(PD); i++) idx_q[i] <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      fidx_q  <= fidx_d;
      vld_q   <= vld_d;
      for (int i = 0; i < int'(PD); i++) idx_q[i] <= idx_d[i];
    end
  end

  assign bus.wire0    = vec_q[67:64];
  assign bus.wire1    = vec_q[63:48];
  assign bus.wire2    = vec_q[47:28];
  assign bus.wire3    = $signed(vec_q[27:7]);
  assign bus.wire4    = vec_q[6:0];
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.fail     = fail_q;
  assign bus.fail_idx = fidx_q;
  assign bus.vec_cnt  = cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Bench for equiv_stim_gen: three parameterisations share one clock; the
// instance under test is scoreboarded every cycle against a software LFSR.
module tb_equiv_stim_gen;
  localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;
  localparam int NV_A = 4, LAT_A = 1;
  localparam int NV_B = 8, LAT_B = 2;
  localparam int NV_C = 1, LAT_C = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  equiv_stim_gen_if if_a ();
  equiv_stim_gen_if if_b ();
  equiv_stim_gen_if if_c ();
  logic [1:0] dbg_a, dbg_b, dbg_c;

  equiv_stim_gen #(.SEED(SEED), .NUM_VEC(NV_A), .LAT(LAT_A)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state_o(dbg_a));
  equiv_stim_gen #(.SEED(SEED), .NUM_VEC(NV_B), .LAT(LAT_B)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state_o(dbg_b));
  equiv_stim_gen #(.SEED(SEED), .NUM_VEC(NV_C), .LAT(LAT_C)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c), .dbg_state_o(dbg_c));

  int nv[3]  = '{NV_A, NV_B, NV_C};
  int lat[3] = '{LAT_A, LAT_B, LAT_C};
  int t[3];
  logic st[3];
  logic [7:0] bad[3];
  logic [90:0] y1[3];
  logic [90:0] y2[3];

  assign if_a.start = st[0];
  assign if_a.y_1   = y1[0];
  assign if_a.y_2   = y2[0];
  assign if_b.start = st[1];
  assign if_b.y_1   = y1[1];
  assign if_b.y_2   = y2[1];
  assign if_c.start = st[2];
  assign if_c.y_1   = y1[2];
  assign if_c.y_2   = y2[2];

  logic [67:0] exp_q[$];
  logic [67:0] last_vec;
  int cur;
  int busy_cnt;
  int checks;
  int failures;

  typedef struct {
    logic [7:0]  mask;
    logic        exp_fail;
    logic [31:0] exp_idx;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [63:0] m_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [67:0] m_vec(input logic [63:0] s);
    return {s[3:0], s[19:4], s[39:20], s[60:40], s[63:61], s[3:0]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic peek(input int s, output logic [67:0] w, output logic b, output logic d,
                      output logic f, output logic [31:0] fi, output logic [31:0] vc,
                      output logic [1:0] ds);
    case (s)
      0: begin
        w = {if_a.wire0, if_a.wire1, if_a.wire2, if_a.wire3, if_a.wire4};
        b = if_a.busy; d = if_a.done; f = if_a.fail; fi = if_a.fail_idx; vc = if_a.vec_cnt; ds = dbg_a;
      end
      1: begin
        w = {if_b.wire0, if_b.wire1, if_b.wire2, if_b.wire3, if_b.wire4};
        b = if_b.busy; d = if_b.done; f = if_b.fail; fi = if_b.fail_idx; vc = if_b.vec_cnt; ds = dbg_b;
      end
      default: begin
        w = {if_c.wire0, if_c.wire1, if_c.wire2, if_c.wire3, if_c.wire4};
        b = if_c.busy; d = if_c.done; f = if_c.fail; fi = if_c.fail_idx; vc = if_c.vec_cnt; ds = dbg_c;
      end
    endcase
  endtask

  task automatic check_reset(input int s);
    logic [67:0] w; logic b, d, f; logic [31:0] fi, vc; logic [1:0] ds;
    peek(s, w, b, d, f, fi, vc, ds);
    chk($sformatf("rst_wires%0d", s), 128'(w), 128'(0));
    chk($sformatf("rst_busy%0d", s), 128'(b), 128'(0));
    chk($sformatf("rst_done%0d", s), 128'(d), 128'(0));
    chk($sformatf("rst_fail%0d", s), 128'(f), 128'(0));
    chk($sformatf("rst_fidx%0d", s), 128'(fi), 128'(0));
    chk($sformatf("rst_vcnt%0d", s), 128'(vc), 128'(0));
    chk($sformatf("rst_state%0d", s), 128'(ds), 128'(0));
  endtask

  // One clock: advance the bench timeline, drive responses, check `cur`.
  task automatic cyc();
    logic [67:0] w; logic b, d, f; logic [31:0] fi, vc; logic [1:0] ds;
    logic [63:0] s;
    int j, n, l, tc;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (st[i] && (t[i] < 0 || t[i] >= nv[i] + lat[i])) begin
        t[i] = 0;
        if (i == cur) begin
          exp_q.delete();
          s = SEED;
          for (int k = 0; k < nv[i]; k++) begin
            exp_q.push_back(m_vec(s));
            s = m_step(s);
          end
          busy_cnt = 0;
        end
      end else if (t[i] >= 0) begin
        t[i]++;
      end
      j = t[i] - lat[i];
      y1[i] = 91'({$urandom(), $urandom(), $urandom()});
      y2[i] = y1[i];
      if (t[i] >= 0 && j >= 0 && j < nv[i] && bad[i][j])
        y2[i] = y1[i] ^ (91'(1) << $urandom_range(90, 0));
    end
    n = nv[cur]; l = lat[cur]; tc = t[cur];
    peek(cur, w, b, d, f, fi, vc, ds);
    if (b) busy_cnt++;
    if (tc >= 0) begin
      chk("busy", 128'(b), 128'(tc < n + l));
      chk("done", 128'(d), 128'(tc >= n + l));
      if (tc < n) begin
        chk("vec_cnt_run", 128'(vc), 128'(tc));
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty: got no expected vector for t=%0d", tc);
        end else begin
          last_vec = exp_q.pop_front();
          chk("stim", 128'(w), 128'(last_vec));
        end
      end else begin
        chk("vec_cnt_end", 128'(vc), 128'(n));
        if (tc < n + l) chk("stim_hold", 128'(w), 128'(last_vec));
      end
      if (tc == 0) begin
        chk("fail_clr", 128'(f), 128'(0));
        chk("fail_idx_clr", 128'(fi), 128'(0));
      end
    end
  endtask

  task automatic finish_checks(input string tag, input logic ef, input logic [31:0] ei);
    logic [67:0] w; logic b, d, f; logic [31:0] fi, vc; logic [1:0] ds;
    peek(cur, w, b, d, f, fi, vc, ds);
    chk({tag, "_done"}, 128'(d), 128'(1));
    chk({tag, "_fail"}, 128'(f), 128'(ef));
    chk({tag, "_fidx"}, 128'(fi), 128'(ei));
    chk({tag, "_vcnt"}, 128'(vc), 128'(nv[cur]));
    chk({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(nv[cur] + lat[cur]));
    chk({tag, "_sb_left"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic run_one(input int s, input logic [7:0] mask, input logic ef,
                         input logic [31:0] ei, input string tag);
    cur = s;
    bad[s] = mask;
    st[s] = 1'b1;
    cyc();
    st[s] = 1'b0;
    repeat (nv[s] + lat[s] + 1) cyc();
    finish_checks(tag, ef, ei);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [67:0] w; logic b, d, f; logic [31:0] fi, vc; logic [1:0] ds;
    checks = 0; failures = 0; cur = 0; busy_cnt = 0; last_vec = '0;
    for (int i = 0; i < 3; i++) begin
      t[i] = -1; st[i] = 1'b0; bad[i] = '0; y1[i] = '0; y2[i] = '0;
    end
    tbl[0] = '{8'h0, 1'b0, 32'd0};
    tbl[1] = '{8'h4, 1'b1, 32'd2};
    tbl[2] = '{8'hA, 1'b1, 32'd1};
    tbl[3] = '{8'h1, 1'b1, 32'd0};
    tbl[4] = '{8'h8, 1'b1, 32'd3};
    tbl[5] = '{8'hF, 1'b1, 32'd0};

    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) check_reset(i);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    cyc();

    // Table: NUM_VEC=4, LAT=1 with assorted mismatch patterns.
    foreach (tbl[r]) run_one(0, tbl[r].mask, tbl[r].exp_fail, tbl[r].exp_idx,
                             $sformatf("tbl%0d", r));

    // LAT=2, only vector 2 mismatches.
    run_one(1, 8'h04, 1'b1, 32'd2, "lat2_v2");

    // LAT=0, single vector, mismatch on vector 0.
    run_one(2, 8'h01, 1'b1, 32'd0, "lat0_v0");

    // Start during RUN is ignored; restart from DONE clears fail and done.
    cur = 0; bad[0] = 8'h02;
    st[0] = 1'b1; cyc();
    st[0] = 1'b1; cyc();
    st[0] = 1'b0;
    repeat (nv[0] + lat[0]) cyc();
    finish_checks("run_start_ignored", 1'b1, 32'd1);
    run_one(0, 8'h00, 1'b0, 32'd0, "restart_from_done");

    // Reset mid-run at vec_cnt=2 of the 8-vector run.
    cur = 1; bad[1] = 8'h00;
    st[1] = 1'b1; cyc();
    st[1] = 1'b0; cyc(); cyc();
    peek(1, w, b, d, f, fi, vc, ds);
    chk("pre_rst_vcnt", 128'(vc), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    check_reset(1);
    for (int i = 0; i < 3; i++) t[i] = -1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_reset(1);
    rst_n = 1'b1;
    cyc();
    peek(1, w, b, d, f, fi, vc, ds);
    chk("post_rst_idle_busy", 128'(b), 128'(0));
    chk("post_rst_idle_done", 128'(d), 128'(0));
    run_one(1, 8'h00, 1'b0, 32'd0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
